// File: rtl/kanagawa_string_handle_allocator.sv
// rtl/kanagawa_string_handle_allocator.sv - string handle free list with per-handle reference counting
module kanagawa_string_handle_allocator #(
    parameter int HANDLE_WIDTH = 10,
    parameter int REF_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    init_done,
    output logic                    alloc_valid,
    input  logic                    alloc_ready,
    output logic [HANDLE_WIDTH-1:0] alloc_handle,
    input  logic                    ref_valid,
    input  logic [HANDLE_WIDTH-1:0] ref_handle,
    input  logic [REF_WIDTH-1:0]    ref_delta,
    output logic                    free_valid,
    output logic [HANDLE_WIDTH-1:0] free_handle,
    output logic [HANDLE_WIDTH-1:0] live_count,
    output logic                    err_underflow,
    output logic                    err_overflow,
    output logic                    err_dead_ref
);
    localparam int NUM_HANDLES = (1 << HANDLE_WIDTH) - 1;
    localparam logic [HANDLE_WIDTH-1:0] LAST_HANDLE = HANDLE_WIDTH'(NUM_HANDLES);
    localparam logic [HANDLE_WIDTH-1:0] LAST_SLOT   = HANDLE_WIDTH'(NUM_HANDLES - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  state, state_nxt;
    logic [HANDLE_WIDTH-1:0] init_idx, init_idx_nxt;
    logic                    init_push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_INIT;
            init_idx <= HANDLE_WIDTH'(1);
        end else begin
            state    <= state_nxt;
            init_idx <= init_idx_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        init_idx_nxt = init_idx;
        init_push    = 1'b0;
        case (state)
            ST_INIT: begin
                init_push = 1'b1;
                if (init_idx == LAST_HANDLE) begin
                    state_nxt = ST_RUN;
                end else begin
                    init_idx_nxt = init_idx + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign init_done = (state == ST_RUN);

    // Free list: circular FIFO, each handle present at most once so it cannot overflow
    logic [HANDLE_WIDTH-1:0] fl_mem [NUM_HANDLES];
    logic [HANDLE_WIDTH-1:0] fl_head, fl_tail, fl_occ;
    logic                    push_en, pop_en;
    logic [HANDLE_WIDTH-1:0] push_data;

    function automatic logic [HANDLE_WIDTH-1:0] slot_inc(input logic [HANDLE_WIDTH-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    assign alloc_valid  = init_done && (fl_occ != '0);
    assign alloc_handle = alloc_valid ? fl_mem[fl_head] : '0;
    assign pop_en       = alloc_valid && alloc_ready;
    // Freed handles are queued during their free_valid pulse, so they are poppable one cycle later
    assign push_en      = init_push || free_valid;
    assign push_data    = init_push ? init_idx : free_handle;

    always_ff @(posedge clk) begin
        if (push_en) begin
            fl_mem[fl_tail] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fl_head <= '0;
            fl_tail <= '0;
            fl_occ  <= '0;
        end else begin
            if (push_en) begin
                fl_tail <= slot_inc(fl_tail);
            end
            if (pop_en) begin
                fl_head <= slot_inc(fl_head);
            end
            if (push_en && !pop_en) begin
                fl_occ <= fl_occ + 1'b1;
            end else if (pop_en && !push_en) begin
                fl_occ <= fl_occ - 1'b1;
            end
        end
    end

    logic [REF_WIDTH-1:0]    rc_mem [2**HANDLE_WIDTH];
    logic                    c1_valid, c1_dead;
    logic [HANDLE_WIDTH-1:0] c1_handle;
    logic [REF_WIDTH-1:0]    c1_delta, c1_count;
    logic [REF_WIDTH+1:0]    c1_sum;
    logic                    c1_active, c1_neg, c1_under, c1_over, c1_wr, c1_zero;
    logic [REF_WIDTH-1:0]    c0_count;
    logic                    c0_dead;

    // Two guard bits: bit REF_WIDTH+1 flags a negative result, bit REF_WIDTH an overflow
    always_comb begin
        c1_sum    = {2'b00, c1_count} + {{2{c1_delta[REF_WIDTH-1]}}, c1_delta};
        c1_active = c1_valid && !c1_dead && (c1_delta != '0);
        c1_neg    = c1_sum[REF_WIDTH+1];
        c1_under  = c1_active && c1_neg;
        c1_over   = c1_active && !c1_neg && c1_sum[REF_WIDTH];
        c1_wr     = c1_active && !c1_neg && !c1_sum[REF_WIDTH];
        c1_zero   = c1_wr && (c1_sum[REF_WIDTH-1:0] == '0);
    end

    // Forward the C1 write-back so back-to-back updates on one handle see the fresh count
    assign c0_count = (c1_wr && (c1_handle == ref_handle)) ? c1_sum[REF_WIDTH-1:0]
                                                           : rc_mem[ref_handle];
    assign c0_dead  = (ref_handle == '0) || (c0_count == '0);

    always_ff @(posedge clk) begin
        if (init_push) begin
            rc_mem[init_idx] <= '0;
        end
        if (pop_en) begin
            rc_mem[alloc_handle] <= REF_WIDTH'(1);
        end
        if (c1_wr) begin
            rc_mem[c1_handle] <= c1_sum[REF_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c1_valid      <= 1'b0;
            c1_dead       <= 1'b0;
            c1_handle     <= '0;
            c1_delta      <= '0;
            c1_count      <= '0;
            free_valid    <= 1'b0;
            free_handle   <= '0;
            live_count    <= '0;
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
            err_dead_ref  <= 1'b0;
        end else begin
            c1_valid    <= ref_valid && init_done;
            c1_dead     <= c0_dead;
            c1_handle   <= ref_handle;
            c1_delta    <= ref_delta;
            c1_count    <= c0_count;
            free_valid  <= c1_zero;
            free_handle <= c1_zero ? c1_handle : '0;
            live_count  <= live_count + HANDLE_WIDTH'(pop_en) - HANDLE_WIDTH'(c1_zero);
            if (c1_under) begin
                err_underflow <= 1'b1;
            end
            if (c1_over) begin
                err_overflow <= 1'b1;
            end
            if (c1_valid && c1_dead) begin
                err_dead_ref <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_kanagawa_string_handle_allocator.sv
// tb/tb_kanagawa_string_handle_allocator.sv - self-checking bench for kanagawa_string_handle_allocator
module tb_kanagawa_string_handle_allocator;
    localparam int HW  = 10;
    localparam int RW  = 8;
    localparam int NUM = (1 << HW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_done, alloc_valid, alloc_ready;
    logic [HW-1:0] alloc_handle, ref_handle, free_handle, live_count;
    logic          ref_valid, free_valid, err_underflow, err_overflow, err_dead_ref;
    logic [RW-1:0] ref_delta;

    int n_cmp = 0;
    int n_bad = 0;

    kanagawa_string_handle_allocator #(.HANDLE_WIDTH(HW), .REF_WIDTH(RW)) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_handle(alloc_handle),
        .ref_valid(ref_valid), .ref_handle(ref_handle), .ref_delta(ref_delta),
        .free_valid(free_valid), .free_handle(free_handle), .live_count(live_count),
        .err_underflow(err_underflow), .err_overflow(err_overflow), .err_dead_ref(err_dead_ref)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_in(input bit p, input bit rv, input int h, input int d);
        alloc_ready = p;
        ref_valid   = rv;
        ref_handle  = HW'(h);
        ref_delta   = d[RW-1:0];
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset(output int cyc);
        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        while (!init_done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (!init_done) begin
            n_cmp++; n_bad++;
            $display("FAIL init_timeout: init_done=%0d after %0d cycles, required 1", init_done, cyc);
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({init_done, alloc_valid, alloc_handle, free_valid, free_handle, live_count,
             err_underflow, err_overflow, err_dead_ref} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: init_done=%0d alloc_valid=%0d alloc_handle=%0d live=%0d required all 0",
                     init_done, alloc_valid, alloc_handle, live_count);
        end
    endtask

    task automatic test_init_pop();
        int cyc;
        do_reset(cyc);
        n_cmp++;
        if (cyc !== NUM) begin
            n_bad++;
            $display("FAIL init_latency: got %0d cycles, required %0d", cyc, NUM);
        end
        for (int h = 1; h <= 3; h++) begin
            n_cmp++;
            if (alloc_valid !== 1'b1 || alloc_handle !== HW'(h)) begin
                n_bad++;
                $display("FAIL init_pop_order: valid=%0d handle=%0d, required 1/%0d", alloc_valid, alloc_handle, h);
            end
            alloc_ready = 1'b1;
            tick();
        end
        alloc_ready = 1'b0;
        n_cmp++;
        if (live_count !== HW'(3)) begin
            n_bad++;
            $display("FAIL init_live: live_count=%0d required 3", live_count);
        end
    endtask

    task automatic test_free_single();
        int cyc;
        do_reset(cyc);
        set_in(1'b1, 1'b0, 0, 0);
        tick();
        set_in(1'b0, 1'b1, 1, -1);
        tick();
        idle();
        n_cmp++;
        if (free_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL free1_early: free_valid=%0d one cycle after ref, required 0", free_valid);
        end
        tick();
        n_cmp++;
        if (free_valid !== 1'b1 || free_handle !== HW'(1) || live_count !== '0) begin
            n_bad++;
            $display("FAIL free1_pulse: valid=%0d handle=%0d live=%0d, required 1/1/0",
                     free_valid, free_handle, live_count);
        end
        alloc_ready = 1'b1;
        for (int h = 2; h <= NUM; h++) begin
            n_cmp++;
            if (alloc_handle !== HW'(h)) begin
                n_bad++;
                $display("FAIL free1_order: alloc_handle=%0d required %0d", alloc_handle, h);
                break;
            end
            tick();
        end
        alloc_ready = 1'b0;
        n_cmp++;
        if (alloc_valid !== 1'b1 || alloc_handle !== HW'(1)) begin
            n_bad++;
            $display("FAIL free1_reuse: valid=%0d handle=%0d, required 1/1", alloc_valid, alloc_handle);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int seen;
        do_reset(cyc);
        set_in(1'b1, 1'b0, 0, 0);
        repeat (5) tick();
        set_in(1'b0, 1'b1, 5, 1);
        tick();
        set_in(1'b0, 1'b1, 5, -1);
        tick();
        idle();
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (free_valid === 1'b1) seen++;
            tick();
        end
        n_cmp++;
        if (seen !== 0 || live_count !== HW'(5)) begin
            n_bad++;
            $display("FAIL b2b_nofree: free pulses=%0d live=%0d, required 0/5", seen, live_count);
        end
        set_in(1'b0, 1'b1, 5, -1);
        tick();
        idle();
        tick();
        n_cmp++;
        if (free_valid !== 1'b1 || free_handle !== HW'(5) || live_count !== HW'(4)) begin
            n_bad++;
            $display("FAIL b2b_free: valid=%0d handle=%0d live=%0d, required 1/5/4",
                     free_valid, free_handle, live_count);
        end
    endtask

    task automatic test_exhaust();
        int cyc;
        do_reset(cyc);
        alloc_ready = 1'b1;
        repeat (NUM) tick();
        alloc_ready = 1'b0;
        n_cmp++;
        if (alloc_valid !== 1'b0 || live_count !== HW'(NUM)) begin
            n_bad++;
            $display("FAIL exhaust_empty: valid=%0d live=%0d, required 0/%0d", alloc_valid, live_count, NUM);
        end
        set_in(1'b0, 1'b1, 7, -1);
        tick();
        idle();
        tick();
        n_cmp++;
        if (free_valid !== 1'b1 || free_handle !== HW'(7) || alloc_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL exhaust_pulse: free_valid=%0d free_handle=%0d alloc_valid=%0d, required 1/7/0",
                     free_valid, free_handle, alloc_valid);
        end
        tick();
        n_cmp++;
        if (alloc_valid !== 1'b1 || alloc_handle !== HW'(7)) begin
            n_bad++;
            $display("FAIL exhaust_reuse: valid=%0d handle=%0d, required 1/7", alloc_valid, alloc_handle);
        end
    endtask

    task automatic test_errors();
        int cyc;
        do_reset(cyc);
        set_in(1'b1, 1'b0, 0, 0);
        repeat (3) tick();
        set_in(1'b0, 1'b1, 2, -2);
        tick(); idle(); tick();
        n_cmp++;
        if (err_underflow !== 1'b1 || free_valid !== 1'b0 || err_overflow !== 1'b0 || err_dead_ref !== 1'b0) begin
            n_bad++;
            $display("FAIL err_under: under=%0d free=%0d over=%0d dead=%0d, required 1/0/0/0",
                     err_underflow, free_valid, err_overflow, err_dead_ref);
        end
        set_in(1'b0, 1'b1, 9, 1);
        tick(); idle(); tick();
        n_cmp++;
        if (err_dead_ref !== 1'b1 || err_overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL err_dead: dead=%0d over=%0d, required 1/0", err_dead_ref, err_overflow);
        end
        repeat (3) begin
            set_in(1'b0, 1'b1, 3, 127);
            tick();
        end
        idle(); tick();
        n_cmp++;
        if (err_overflow !== 1'b1 || free_valid !== 1'b0 || err_underflow !== 1'b1) begin
            n_bad++;
            $display("FAIL err_over: over=%0d free=%0d under=%0d, required 1/0/1",
                     err_overflow, free_valid, err_underflow);
        end
        set_in(1'b0, 1'b1, 3, -127); tick();
        set_in(1'b0, 1'b1, 3, -127); tick();
        n_cmp++;
        if (free_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL err_over_keep: free_valid=%0d while draining 255, required 0", free_valid);
        end
        set_in(1'b0, 1'b1, 3, -1); tick();
        idle(); tick();
        n_cmp++;
        if (free_valid !== 1'b1 || free_handle !== HW'(3)) begin
            n_bad++;
            $display("FAIL err_over_count: valid=%0d handle=%0d, required 1/3", free_valid, free_handle);
        end
        set_in(1'b0, 1'b1, 2, -1); tick();
        idle(); tick();
        n_cmp++;
        if (free_valid !== 1'b1 || free_handle !== HW'(2) || live_count !== HW'(1)) begin
            n_bad++;
            $display("FAIL err_under_count: valid=%0d handle=%0d live=%0d, required 1/2/1",
                     free_valid, free_handle, live_count);
        end
    endtask

    task automatic test_mid_reset();
        int cyc;
        do_reset(cyc);
        set_in(1'b1, 1'b0, 0, 0);
        repeat (40) tick();
        set_in(1'b0, 1'b1, 0, 1);
        tick(); idle(); tick();
        n_cmp++;
        if (live_count !== HW'(40) || err_dead_ref !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_pre: live=%0d dead=%0d, required 40/1", live_count, err_dead_ref);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({init_done, alloc_valid, alloc_handle, free_valid, live_count, err_dead_ref} !== '0) begin
            n_bad++;
            $display("FAIL midrst_async: init_done=%0d alloc_valid=%0d live=%0d dead=%0d, required all 0",
                     init_done, alloc_valid, live_count, err_dead_ref);
        end
        do_reset(cyc);
        n_cmp++;
        if (live_count !== '0 || alloc_valid !== 1'b1 || alloc_handle !== HW'(1)) begin
            n_bad++;
            $display("FAIL midrst_reinit: live=%0d valid=%0d handle=%0d, required 0/1/1",
                     live_count, alloc_valid, alloc_handle);
        end
    endtask

    task automatic test_random();
        int cnt [0:NUM];
        int fq[$];
        int pend_h[$];
        int pend_t[$];
        int ev_h[$];
        int ev_t[$];
        int live_q[$];
        int live_sched[int];
        int m_live, t, l_bad, h, d, res, idx, dummy, exp_fh;
        bit m_under, m_over, m_dead, do_pop, do_ref, exp_fv;
        do_reset(dummy);
        for (int i = 0; i <= NUM; i++) cnt[i] = 0;
        for (int i = 1; i <= NUM; i++) fq.push_back(i);
        m_live = 0; t = 0; l_bad = 0;
        m_under = 0; m_over = 0; m_dead = 0;
        for (int it = 0; it < 1003 && l_bad < 10; it++) begin
            if (live_sched.exists(t)) m_live += live_sched[t];
            while (pend_t.size() > 0 && pend_t[0] <= t) begin
                fq.push_back(pend_h.pop_front());
                dummy = pend_t.pop_front();
            end
            exp_fv = 1'b0; exp_fh = 0;
            if (ev_t.size() > 0 && ev_t[0] == t) begin
                exp_fv = 1'b1;
                exp_fh = ev_h.pop_front();
                dummy  = ev_t.pop_front();
            end
            n_cmp++;
            if (free_valid !== exp_fv) begin
                n_bad++; l_bad++;
                $display("FAIL rand_free_valid: cycle %0d got %0d required %0d", t, free_valid, exp_fv);
            end
            if (exp_fv) begin
                n_cmp++;
                if (free_handle !== HW'(exp_fh)) begin
                    n_bad++; l_bad++;
                    $display("FAIL rand_free_handle: cycle %0d got %0d required %0d", t, free_handle, exp_fh);
                end
            end
            n_cmp++;
            if (alloc_valid !== (fq.size() > 0)) begin
                n_bad++; l_bad++;
                $display("FAIL rand_alloc_valid: cycle %0d got %0d required %0d", t, alloc_valid, fq.size() > 0);
            end
            if (fq.size() > 0) begin
                n_cmp++;
                if (alloc_handle !== HW'(fq[0])) begin
                    n_bad++; l_bad++;
                    $display("FAIL rand_alloc_handle: cycle %0d got %0d required %0d", t, alloc_handle, fq[0]);
                end
            end
            n_cmp++;
            if (live_count !== HW'(m_live)) begin
                n_bad++; l_bad++;
                $display("FAIL rand_live: cycle %0d got %0d required %0d", t, live_count, m_live);
            end
            do_pop = (it < 1000) && ($urandom_range(0, 99) < 35);
            do_ref = (it < 1000) && ($urandom_range(0, 99) < 60);
            h = 0; d = 0;
            if (do_ref) begin
                if (live_q.size() > 0 && $urandom_range(0, 15) != 0)
                    h = live_q[$urandom_range(0, live_q.size() - 1)];
                else
                    h = $urandom_range(0, NUM);
                case ($urandom_range(0, 9))
                    0:          d = 2;
                    1:          d = -2;
                    2, 3, 4, 5: d = 1;
                    default:    d = -1;
                endcase
            end
            set_in(do_pop, do_ref, h, d);
            if (do_ref) begin
                if (h == 0 || cnt[h] == 0) begin
                    m_dead = 1'b1;
                end else begin
                    res = cnt[h] + d;
                    if (res < 0) m_under = 1'b1;
                    else if (res > 255) m_over = 1'b1;
                    else begin
                        cnt[h] = res;
                        if (res == 0) begin
                            ev_h.push_back(h);   ev_t.push_back(t + 2);
                            pend_h.push_back(h); pend_t.push_back(t + 3);
                            if (!live_sched.exists(t + 2)) live_sched[t + 2] = 0;
                            live_sched[t + 2] -= 1;
                            idx = 0;
                            foreach (live_q[k]) if (live_q[k] == h) idx = k;
                            live_q.delete(idx);
                        end
                    end
                end
            end
            if (do_pop && fq.size() > 0) begin
                h = fq.pop_front();
                cnt[h] = 1;
                live_q.push_back(h);
                if (!live_sched.exists(t + 1)) live_sched[t + 1] = 0;
                live_sched[t + 1] += 1;
            end
            tick();
            t++;
        end
        idle();
        tick();
        n_cmp++;
        if ({err_underflow, err_overflow, err_dead_ref} !== {m_under, m_over, m_dead}) begin
            n_bad++;
            $display("FAIL rand_flags: under/over/dead=%0d%0d%0d required %0d%0d%0d",
                     err_underflow, err_overflow, err_dead_ref, m_under, m_over, m_dead);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_init_pop();
        test_free_single();
        test_back_to_back();
        test_exhaust();
        test_errors();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
